// File: rtl/systolic_skew_feeder.sv
// Edge sequencer for the output-stationary systolic array: latches A/B on start,
// then streams them diagonally skewed into the west/north edges with clear/done strobes.
module systolic_skew_feeder #(
  parameter int WIDTH = 8,
  parameter int SIZE  = 4,
  parameter int DRAIN = SIZE + 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [WIDTH*SIZE*SIZE-1:0]    A,
  input  logic [WIDTH*SIZE*SIZE-1:0]    B,
  output logic                          busy,
  output logic                          acc_clr,
  output logic                          edge_valid,
  output logic [WIDTH*SIZE-1:0]         a_edge,
  output logic [WIDTH*SIZE-1:0]         b_edge,
  output logic                          done
);

  localparam int STEPS = 2 * SIZE - 1;
  localparam int CMAX  = (STEPS > DRAIN) ? STEPS : DRAIN;
  localparam int CW    = $clog2(CMAX);

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_STREAM, S_DRAIN} state_t;

  state_t             state, nstate;
  logic [CW-1:0]      cnt, ncnt;
  logic [WIDTH-1:0]   aq [SIZE][SIZE];
  logic [WIDTH-1:0]   bq [SIZE][SIZE];

  logic               busy_n, clr_n, ev_n, done_n;
  logic [WIDTH*SIZE-1:0] a_n, b_n;

  // Outputs are decoded from the next state/count and registered, so each
  // output flop lines up with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      acc_clr    <= 1'b0;
      edge_valid <= 1'b0;
      done       <= 1'b0;
      a_edge     <= '0;
      b_edge     <= '0;
    end else begin
      state      <= nstate;
      cnt        <= ncnt;
      busy       <= busy_n;
      acc_clr    <= clr_n;
      edge_valid <= ev_n;
      done       <= done_n;
      a_edge     <= a_n;
      b_edge     <= b_n;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == S_IDLE && start) begin
      for (int unsigned i = 0; i < SIZE; i++) begin
        for (int unsigned k = 0; k < SIZE; k++) begin
          aq[i][k] <= A[(i*SIZE+k)*WIDTH +: WIDTH];
          bq[i][k] <= B[(i*SIZE+k)*WIDTH +: WIDTH];
        end
      end
    end
  end

  always_comb begin
    nstate = state;
    ncnt   = '0;
    case (state)
      S_IDLE:   if (start) nstate = S_CLEAR;
      S_CLEAR:  nstate = S_STREAM;
      S_STREAM: begin
        if (cnt == CW'(STEPS - 1)) nstate = S_DRAIN;
        else                       ncnt   = cnt + 1'b1;
      end
      S_DRAIN: begin
        if (cnt == CW'(DRAIN - 1)) nstate = S_IDLE;
        else                       ncnt   = cnt + 1'b1;
      end
      default: nstate = S_IDLE;
    endcase
  end

  always_comb begin
    busy_n = (nstate != S_IDLE);
    clr_n  = (nstate == S_CLEAR);
    ev_n   = (nstate == S_STREAM);
    done_n = (nstate == S_DRAIN) && (ncnt == CW'(DRAIN - 1));
    a_n    = '0;
    b_n    = '0;
    if (ev_n) begin
      // Lane i carries element k exactly when step t == i + k.
      for (int unsigned i = 0; i < SIZE; i++) begin
        for (int unsigned k = 0; k < SIZE; k++) begin
          if (32'(ncnt) == i + k) begin
            a_n[i*WIDTH +: WIDTH] = aq[i][k];
            b_n[i*WIDTH +: WIDTH] = bq[k][i];
          end
        end
      end
    end
  end

endmodule

// File: doc/systolic_skew_feeder.md
# systolic_skew_feeder

Sequencer that drives the west and north edges of the output-stationary systolic multiply array. It captures a pair of SIZE×SIZE signed operand matrices on a start handshake. It then streams them into the array diagonally skewed: row i of A is delayed i cycles and column j of B is delayed j cycles. It also generates the accumulator-clear and completion strobes that bracket one matrix product.

## Interface
- WIDTH, 8, operand element width (signed two's complement)
- SIZE, 4, array dimension; legal range 2..16
- DRAIN, SIZE+1, zero-padded cycles after the last operand so the far PE and the C capture register settle
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request a new product; sampled only in IDLE
- A  in  WIDTH×SIZE×SIZE  signed matrix, row-major [row][col]; sampled on the accepted start edge
- B  in  WIDTH×SIZE×SIZE  signed matrix; sampled on the accepted start edge
- busy  out  1  high in every state except IDLE
- acc_clr  out  1  one-cycle pulse that zeroes all PE accumulators
- edge_valid  out  1  high during STREAM
- a_edge  out  WIDTH×SIZE  per-row west-edge operand, signed
- b_edge  out  WIDTH×SIZE  per-column north-edge operand, signed
- done  out  1  one-cycle pulse; C holds the final product in the same cycle

## Operation
- States: IDLE → CLEAR → STREAM → DRAIN → IDLE.
- IDLE:
  - If start=1 at a clock edge, latch A and B into internal registers and go to CLEAR.
  - Otherwise remain in IDLE.
- CLEAR: lasts 1 cycle. acc_clr=1 and both edges are zero.
- STREAM:
  - Lasts 2·SIZE−1 cycles. The step counter t runs 0..2·SIZE−2, and edge_valid=1.
  - a_edge[i] = Aq[i][t−i] when 0 ≤ t−i < SIZE; otherwise 0.
  - b_edge[j] = Bq[t−j][j] when 0 ≤ t−j < SIZE; otherwise 0.
- DRAIN: lasts DRAIN cycles. Both edges are 0 and edge_valid=0. done=1 in the final DRAIN cycle.
- Register use:
  - Operands are taken only from the latched copies (Aq, Bq).
  - Changes on A, B or start while busy have no effect. start during busy is dropped, not queued.
- Arithmetic: no arithmetic on the data path. Values pass through bit-exact with sign preserved. Zero padding is signed 0.
- Counter:
  - One shared counter, width clog2(max(2·SIZE−1, DRAIN)).
  - Reloaded to 0 on every state entry.
  - No wrap-around is reachable.

## Timing
- Every output is registered and is a function of the current state and counter only.
- Reset (rst=1 at an edge) forces the next cycle to IDLE with counter=0 and all outputs 0: busy, acc_clr, edge_valid, done, a_edge, b_edge.
- Reset mid-operation:
  - Aborts immediately. No done is issued.
  - Aq and Bq keep stale contents, but these are unobservable.
- rst and start high at the same edge: reset wins and start is not accepted.
- Cycle map for an accepted start at the edge ending cycle N:
  - CLEAR at N+1.
  - STREAM at N+2 .. N+2·SIZE.
  - DRAIN at N+2·SIZE+1 .. N+2·SIZE+DRAIN.
  - done at N+2·SIZE+DRAIN; IDLE at the next cycle.
- Start latency: the earliest next start can be sampled is the edge ending the first IDLE cycle. The minimum start-to-start period is 2·SIZE+DRAIN+1 cycles.
- For SIZE=4 with default DRAIN=5:
  - CLEAR at N+1.
  - STREAM N+2..N+8.
  - DRAIN N+9..N+13.
  - done at N+13.
  - Period 14 cycles.

## Test plan
- Reset: hold rst for 2 cycles with start=1 → all outputs 0, busy=0, and no state change for the 3 cycles after release while start=0.
- Skew pattern: A[i][k]=16·i+k, B[k][j]=−(16·k+j), SIZE=4, start at N.
  - At N+2: a_edge=(0,0,0,0), b_edge=(0,0,0,0) except a_edge[0]=0 and b_edge[0]=0, which are genuine values.
  - At N+5 (t=3): a_edge=(3,18,33,48) and b_edge=(−48,−33,−18,−3).
  - At N+8 (t=6): only a_edge[3]=51 and b_edge[3]=−51 are nonzero.
- Strobe timing: acc_clr high only at N+1, edge_valid high exactly N+2..N+8, done high only at N+13, busy high N+1..N+13.
- Busy-start and operand isolation: pulse start and change A/B at N+6 → stream unaffected and no second run. Start at N+14 runs with the new operands.
- Mid-run reset: assert rst at N+5 → outputs all 0 at N+6 and no done. A fresh start then produces the full cycle map.
- End-to-end with the array:
  - A=identity, B[k][j]=k−j, with signed extremes −128/127 in B[0][0]/B[3][3].
  - Result: C equals B when done is high. Back-to-back products with A=all −128, B=all 127 give C=−65024 everywhere, with no carryover from the previous product.
